// File: rtl/simon_pkg.sv
// simon_pkg: shared state codes, FSM enum, LFSR taps, level clamp and display patterns for the Simon game.
package simon_pkg;
  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_GAME  = 2'b01;
  localparam logic [1:0] ST_USER  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;
  typedef enum logic [2:0] {
    F_READY, F_SHOW_ON, F_SHOW_OFF, F_GAP, F_WAIT, F_HOLD, F_OVER
  } fsm_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // Active-low segment patterns {g,f,e,d,c,b,a} for digits 0-9.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic [2:0] clamp_level(input logic [2:0] sw);
    return sw == 3'd0 ? 3'd1 : (sw > 3'd5 ? 3'd5 : sw);
  endfunction
endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: 16-bit Fibonacci LFSR; load advances from the seed so pad_o is element 0 right after a load.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        step_i,
  output logic [1:0]  pad_o
);
  logic [15:0] s_q, s_d, src;
  always_comb begin
    src = load_i ? seed_i : s_q;
    s_d = (load_i || step_i) ? {src[14:0], ^(src & LFSR_TAPS)} : s_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) s_q <= 16'h0001;
    else s_q <= s_d;
  end
  assign pad_o = s_q[1:0];
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon game control; plays back the LFSR sequence, checks key presses, tracks rounds to win/lose.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int BASE_ON_CYCLES = 25_000_000,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] level_sw,
  input  logic       start,
  input  logic [3:0] key_n,
  output logic [1:0] state,
  output logic [2:0] level,
  output logic [3:0] color,
  output logic [4:0] round,
  output logic       win,
  output logic       lose
);
  fsm_e        fsm_q, fsm_d;
  logic [15:0] cnt_q, seed_q, seed_d, ld_seed;
  logic [3:0]  sync1_q, sync2_q, hold_q, hold_d, k, exp_k;
  logic [27:0] tmr_q, tmr_d, on_t, off_t;
  logic [4:0]  idx_q, idx_d, round_q, round_d;
  logic [2:0]  level_q, level_d;
  logic        win_q, win_d, lose_q, lose_d, load, step, more;
  logic [1:0]  pad;

  simon_lfsr u_lfsr (
    .clk(CLOCK_50), .rst_n(reset), .load_i(load), .seed_i(ld_seed), .step_i(step), .pad_o(pad)
  );

  assign k     = ~sync2_q;
  assign exp_k = 4'b0001 << pad;
  assign on_t  = 28'(BASE_ON_CYCLES) >> (level_q - 3'd1);
  assign off_t = on_t >> 1;
  assign more  = (idx_q + 5'd1) < round_q;

  always_comb begin
    fsm_d   = fsm_q;
    seed_d  = seed_q;
    ld_seed = seed_q;
    hold_d  = hold_q;
    tmr_d   = tmr_q + 28'd1;
    idx_d   = idx_q;
    round_d = round_q;
    level_d = level_q;
    win_d   = win_q;
    lose_d  = lose_q;
    load    = 1'b0;
    step    = 1'b0;
    case (fsm_q)
      F_READY, F_OVER: if (start) begin
        level_d = clamp_level(level_sw);
        seed_d  = cnt_q | 16'h0001;
        ld_seed = cnt_q | 16'h0001;
        load    = 1'b1;
        round_d = 5'd1;
        idx_d   = 5'd0;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        tmr_d   = 28'd0;
        fsm_d   = F_SHOW_ON;
      end
      F_SHOW_ON: if (tmr_q == on_t - 28'd1) begin
        tmr_d = 28'd0;
        fsm_d = F_SHOW_OFF;
      end
      F_SHOW_OFF: if (tmr_q == off_t - 28'd1) begin
        tmr_d = 28'd0;
        step  = more;
        load  = !more;
        idx_d = more ? idx_q + 5'd1 : 5'd0;
        fsm_d = more ? F_SHOW_ON : F_WAIT;
      end
      F_GAP: if (tmr_q == off_t - 28'd1) begin
        tmr_d = 28'd0;
        fsm_d = F_SHOW_ON;
      end
      F_WAIT: begin
        if (k == 4'd0) begin
          if (tmr_q == 28'(TIMEOUT_CYCLES - 1)) begin
            lose_d = 1'b1;
            fsm_d  = F_OVER;
          end
        end else if ($onehot(k) && k == exp_k) begin
          hold_d = k;
          fsm_d  = F_HOLD;
        end else begin
          lose_d = 1'b1;
          fsm_d  = F_OVER;
        end
      end
      F_HOLD: if (k == 4'd0) begin
        tmr_d = 28'd0;
        if (more) begin
          step  = 1'b1;
          idx_d = idx_q + 5'd1;
          fsm_d = F_WAIT;
        end else if (round_q == 5'(MAX_LEN)) begin
          win_d = 1'b1;
          fsm_d = F_OVER;
        end else begin
          round_d = round_q + 5'd1;
          load    = 1'b1;
          idx_d   = 5'd0;
          fsm_d   = F_GAP;
        end
      end
      default: fsm_d = F_READY;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      fsm_q   <= F_READY;
      cnt_q   <= 16'd0;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      seed_q  <= 16'd0;
      hold_q  <= 4'd0;
      tmr_q   <= 28'd0;
      idx_q   <= 5'd0;
      round_q <= 5'd0;
      level_q <= 3'd1;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_q + 16'd1;
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      seed_q  <= seed_d;
      hold_q  <= hold_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      level_q <= level_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign state = fsm_q == F_READY ? ST_READY :
                 fsm_q == F_OVER  ? ST_OVER  :
                 (fsm_q == F_WAIT || fsm_q == F_HOLD) ? ST_USER : ST_GAME;
  assign color = fsm_q == F_SHOW_ON ? exp_k : (fsm_q == F_HOLD ? hold_q : 4'd0);
  assign round = round_q;
  assign level = level_q;
  assign win   = win_q;
  assign lose  = lose_q;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: directed and random stimulus against a timeline model of the Simon game.
module tb_simon_sequencer;
  localparam int ML = 3, BON = 32, TO = 100;
  logic clk = 1'b0, reset, start;
  logic [2:0] level_sw, level;
  logic [3:0] key_n, color;
  logic [1:0] state;
  logic [4:0] round;
  logic win, lose;

  simon_sequencer #(.MAX_LEN(ML), .BASE_ON_CYCLES(BON), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .reset(reset), .level_sw(level_sw), .start(start), .key_n(key_n),
    .state(state), .level(level), .color(color), .round(round), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  logic [1:0] e_state;
  logic [3:0] e_color;
  logic [4:0] e_round;
  logic e_win, e_lose;
  logic [2:0] e_level;
  logic [3:0] m_elem [16];
  bit m_over, ab;
  logic s_start;
  logic [2:0] s_lsw;
  logic [15:0] s_fc, fc;
  logic [3:0] kd1, kd2, kcur;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  function automatic logic [3:0] elem(input logic [15:0] seed, input int i);
    logic [15:0] s = seed;
    for (int j = 0; j <= i; j++) s = lfsr_adv(s);
    return 4'b0001 << s[1:0];
  endfunction
  function automatic logic [2:0] mclamp(input logic [2:0] v);
    return v == 0 ? 3'd1 : (v > 5 ? 3'd5 : v);
  endfunction
  function automatic int ontime(input logic [2:0] l);
    return BON >> (int'(l) - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    s_start = start;
    s_lsw = level_sw;
    s_fc = fc;
    kcur = ~kd2;
    if (!reset) begin
      ab = 1'b1; fc = 16'd0; kd1 = 4'hF; kd2 = 4'hF;
    end else begin
      ab = 1'b0; fc = fc + 16'd1; kd2 = kd1; kd1 = key_n;
    end
  endtask

  task automatic ex(input logic [1:0] st, input logic [3:0] c);
    e_state = st;
    e_color = c;
  endtask

  task automatic rst_vals();
    m_over = 1'b0; e_round = 5'd0; e_win = 1'b0; e_lose = 1'b0; e_level = 3'd1;
    ex(2'd0, 4'd0);
  endtask

  task automatic game();
    int on, off, w;
    logic [3:0] h;
    on = ontime(e_level);
    off = on >> 1;
    for (int r = 1; r <= ML; r++) begin
      e_round = 5'(r);
      if (r > 1) repeat (off) begin ex(2'd1, 4'd0); tick(); if (ab) return; end
      for (int i = 0; i < r; i++) begin
        repeat (on) begin ex(2'd1, m_elem[i]); tick(); if (ab) return; end
        repeat (off) begin ex(2'd1, 4'd0); tick(); if (ab) return; end
      end
      for (int i = 0; i < r; i++) begin
        w = 0;
        forever begin
          ex(2'd2, 4'd0); tick(); if (ab) return;
          if (kcur == 4'd0) begin
            w++;
            if (w == TO) begin e_lose = 1'b1; m_over = 1'b1; return; end
          end else if (kcur == m_elem[i]) break;
          else begin e_lose = 1'b1; m_over = 1'b1; return; end
        end
        h = kcur;
        do begin ex(2'd2, h); tick(); if (ab) return; end while (kcur != 4'd0);
      end
    end
    e_win = 1'b1;
    m_over = 1'b1;
  endtask

  initial begin
    fc = 16'd0; kd1 = 4'hF; kd2 = 4'hF;
    rst_vals();
    forever begin
      ex(m_over ? 2'd3 : 2'd0, 4'd0);
      tick();
      if (ab) rst_vals();
      else if (s_start) begin
        e_level = mclamp(s_lsw);
        for (int i = 0; i < 16; i++) m_elem[i] = elem(s_fc | 16'h0001, i);
        e_round = 5'd1; e_win = 1'b0; e_lose = 1'b0;
        game();
        if (ab) rst_vals();
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("state", state, e_state);
    chk("color", color, e_color);
    chk("round", round, e_round);
    chk("win", win, e_win);
    chk("lose", lose, e_lose);
    chk("level", level, e_level);
  end

  task automatic wait_state(input logic [1:0] st, input int budget);
    int n = 0;
    while (state !== st && n < budget) begin @(negedge clk); n++; end
    chk("wait_state", state, st);
  endtask

  task automatic start_game(input logic [2:0] lsw);
    level_sw = lsw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic play_round(input int r);
    wait_state(2'd2, 3000);
    chk("round_step", round, r);
    for (int i = 0; i < r; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      key_n = ~m_elem[i];
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        key_n = ~(m_elem[i] | 4'(1 << $urandom_range(0, 3)));
        @(negedge clk);
      end
      key_n = 4'hF;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  int n, hold;
  logic [3:0] wrong;

  initial begin
    reset = 1'b0; start = 1'b0; key_n = 4'hF; level_sw = 3'd1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_state", state, 2'd0);
    chk("rst_round", round, 5'd0);
    chk("rst_level", level, 3'd1);
    chk("rst_color", color, 4'd0);
    chk("model_e0", elem(16'h0009, 0), 4'b0100);
    chk("model_e1", elem(16'h0009, 1), 4'b0001);
    chk("model_e2", elem(16'h0009, 2), 4'b0001);
    chk("model_clamp0", mclamp(3'd0), 3'd1);
    chk("model_clamp7", mclamp(3'd7), 3'd5);
    chk("model_on3", ontime(3'd3), 8);
    reset = 1'b1;
    n = 0;
    while (fc != 16'd9 && n < 100) begin @(negedge clk); n++; end
    start_game(3'd1);
    chk("first_color", color, 4'b0100);
    chk("first_state", state, 2'd1);
    n = 0;
    while (color != 4'd0 && n < 200) begin @(negedge clk); n++; end
    chk("on_time_l1", n, 32);
    n = 0;
    while (state == 2'd1 && color == 4'd0 && n < 200) begin @(negedge clk); n++; end
    chk("off_time_l1", n, 16);
    chk("user_state", state, 2'd2);
    for (int r = 1; r <= ML; r++) play_round(r);
    chk("win_state", state, 2'd3);
    chk("win_flag", win, 1'b1);
    chk("win_nolose", lose, 1'b0);
    chk("win_color", color, 4'd0);

    start_game(3'd1);
    play_round(1);
    wait_state(2'd2, 3000);
    wrong = {m_elem[0][2:0], m_elem[0][3]};
    key_n = ~wrong;
    @(negedge clk); chk("wrong_e1", state, 2'd2);
    @(negedge clk); chk("wrong_e2", state, 2'd2);
    @(negedge clk); chk("wrong_e3", state, 2'd3);
    chk("wrong_lose", lose, 1'b1);
    chk("wrong_round", round, 5'd2);
    key_n = 4'hF;

    start_game(3'd1);
    wait_state(2'd2, 3000);
    n = 0;
    while (state == 2'd2 && n < 1000) begin @(negedge clk); n++; end
    chk("timeout_len", n, TO);
    chk("timeout_lose", lose, 1'b1);

    start_game(3'd2);
    wait_state(2'd2, 3000);
    key_n = 4'b1100;
    repeat (3) @(negedge clk);
    chk("multi_state", state, 2'd3);
    chk("multi_lose", lose, 1'b1);
    key_n = 4'hF;

    start_game(3'd3);
    chk("level3", level, 3'd3);
    n = 0;
    while (color != 4'd0 && n < 200) begin @(negedge clk); n++; end
    chk("on_time_l3", n, 8);
    wait_state(2'd3, 3000);
    start_game(3'd7);
    chk("level7", level, 3'd5);
    n = 0;
    while (color != 4'd0 && n < 200) begin @(negedge clk); n++; end
    chk("on_time_l7", n, 2);
    wait_state(2'd3, 3000);

    start_game(3'd1);
    play_round(1);
    n = 0;
    while (!(state == 2'd1 && color != 4'd0) && n < 500) begin @(negedge clk); n++; end
    chk("r2_show", round, 5'd2);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_state", state, 2'd0);
    chk("midrst_color", color, 4'd0);
    chk("midrst_round", round, 5'd0);
    reset = 1'b1;
    @(negedge clk);

    start_game(3'd1);
    wait_state(2'd2, 3000);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("start_ign_state", state, 2'd2);
    chk("start_ign_round", round, 5'd1);
    wait_state(2'd3, 3000);

    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0, 1: key_n = 4'hF;
          2: key_n = ~(4'b0001 << $urandom_range(0, 3));
          default: key_n = 4'($urandom);
        endcase
        hold = $urandom_range(1, 30);
      end
      hold--;
      start = ($urandom_range(0, 60) == 0);
      level_sw = 3'($urandom);
      reset = ($urandom_range(0, 1500) != 0);
      @(negedge clk);
    end
    reset = 1'b1; start = 1'b0; key_n = 4'hF;
    repeat (5) @(negedge clk);
    summary();
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    summary();
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Game-control stage directly upstream of the grid/VGA display top.
- Generates the pseudo-random Simon pad sequence and plays it back one step per round, lighting one pad at a time.
- Collects and checks user key presses, and advances rounds up to a win or a loss.
- Drives the state, level and color signals that the display consumes, replacing the raw switch/key wiring.

Parameters:
- MAX_LEN, 16, sequence length needed to win (1..16)
- BASE_ON_CYCLES, 25_000_000, pad on-time at level 1 (0.5 s at 50 MHz)
- TIMEOUT_CYCLES, 150_000_000, max wait for the next user press (3 s)

Ports:
- CLOCK_50  in   1  system clock
- reset     in   1  synchronous, active-low reset
- level_sw  in   3  difficulty switch; 0 treated as 1, 6/7 treated as 5
- start     in   1  begin new game (level-sensitive, sampled in READY/OVER)
- key_n     in   4  raw pad buttons, active-low, asynchronous
- state     out  2  00 ready, 01 game (playback), 10 user, 11 over
- level     out  3  latched effective level 1..5
- color     out  4  one-hot lit pad; 0000 = none lit
- round     out  5  current round 1..MAX_LEN; 0 in READY
- win       out  1  high in OVER if all MAX_LEN rounds were matched
- lose      out  1  high in OVER on wrong key, multi-key press or timeout

Behaviour:
- Reset (reset==0 at a CLOCK_50 edge): FSM=READY, state=00, color=0, round=0, win=0, lose=0, level=1, free counter=0, LFSR=0001, sync flops=1111.
- Free counter: 16-bit, +1 every cycle, wraps.
- Key sync: 2-flop synchroniser, inverted to active-high `k`. The FSM sees a press on the 3rd edge after the pin falls.
- Level and timing:
  - `level` is latched from level_sw when start is accepted.
  - on_t = BASE_ON_CYCLES >> (level-1).
  - off_t = on_t >> 1.
- LFSR:
  - 16-bit Fibonacci; fb = s[15]^s[13]^s[12]^s[10]; s <= {s[14:0],fb}.
  - Sequence element i = s[1:0] after i+1 steps from the seed, mapped to pad one-hot (1 << s[1:0]).
  - Seed = free counter | 1, captured on the start-accept edge.
  - Every playback and every check re-seeds and regenerates, so there is no sequence RAM.
- FSM:
  - READY (00): start=1 -> latch level, capture seed, round=1, win=lose=0 -> SHOW_ON.
  - SHOW_ON (01):
    - color = element[idx] for on_t cycles, then -> SHOW_OFF.
    - idx starts at 0 each round.
  - SHOW_OFF (01):
    - color=0 for off_t cycles.
    - idx+1 < round -> step LFSR, SHOW_ON.
    - else -> reseed, idx=0, USER_WAIT.
  - USER_WAIT (10):
    - color=0; timeout counter runs.
    - k==0: counter at TIMEOUT_CYCLES-1 -> lose=1, OVER.
    - k one-hot and equal to the expected element -> color=k, USER_HOLD.
    - k one-hot but wrong, or two or more bits set -> lose=1, OVER, same cycle.
  - USER_HOLD (10):
    - color=k-latched until k==0.
    - On release: idx+1 < round -> step LFSR, idx+1, clear timeout, USER_WAIT.
    - idx+1 == round == MAX_LEN -> win=1, OVER.
    - else -> round+1, reseed, idx=0, SHOW_OFF-style gap of off_t, then SHOW_ON.
    - An extra key pressed while holding is ignored.
  - OVER (11):
    - color=0; win/lose held.
    - start=1 -> behaves as READY accept; round, win and lose reset.
  - start is ignored in every other state.
- Reset mid-game returns to READY on that edge with all outputs at reset values.
- Counters are 28-bit. on_t >= 1 is guaranteed for BASE_ON_CYCLES >= 32.

Decomposition:
- Shared package simon_pkg holds:
  - state codes ST_READY/ST_GAME/ST_USER/ST_OVER
  - internal FSM enum
  - LFSR tap constant
  - level clamp function
  - seven-segment patterns reused by the display top
- One natural sub-module, simon_lfsr:
  - inputs: load, seed, step
  - output: pad[1:0]

Test Plan:
- Parameters for all directed tests: MAX_LEN=3, BASE_ON_CYCLES=32, TIMEOUT_CYCLES=100.
- Reset, then hold start from cycle 9 (seed=0x0009), level_sw=1 -> state=01, round=1, color = one-hot of element0 for exactly 32 cycles, then 0 for 16 cycles, then state=10.
- Play the correct keys for every round -> round steps 1,2,3. After the 3rd release: state=11, win=1, lose=0, color=0.
- Press a wrong key in round 2 -> lose=1 and state=11 on the 3rd edge after the pin edge; round stays 2.
- In USER_WAIT press no key -> exactly 100 cycles later lose=1, state=11. Repeat with two keys pressed together -> lose=1.
- level_sw=3 and level_sw=7 -> on-times of 8 and 2 cycles; level output reads 3 and 5.
- Assert reset during SHOW_ON of round 2 -> next edge: state=00, color=0, round=0. Toggle start in USER state -> no effect.
